// File: rtl/busca_instrucao.sv
// busca_instrucao: instruction fetch stage with PC, req/ack memory port and valid/ready instruction output
module busca_instrucao #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        desvio_en,
    input  logic [31:0] desvio_alvo,
    output logic        erro_alinhamento
);
    typedef enum logic [1:0] {BUSCA, VALIDO, DESCARTA, ERRO} estado_t;
    estado_t     state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_pend_q, pc_pend_d, instr_q, instr_d, pc_instr_q, pc_instr_d;
    logic        alvo_ok, buscando;
    assign alvo_ok  = desvio_alvo[1:0] == 2'b00;
    assign buscando = state_q == BUSCA || state_q == DESCARTA;
    assign imem_req         = rst_n && buscando;
    assign imem_addr        = buscando ? pc_q : 32'h0;
    assign instr_valid      = state_q == VALIDO;
    assign erro_alinhamento = state_q == ERRO;
    assign instr            = instr_q;
    assign pc_instr         = pc_instr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUSCA;
            pc_q       <= RESET_PC;
            pc_pend_q  <= 32'h0;
            instr_q    <= 32'h0;
            pc_instr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_pend_q  <= pc_pend_d;
            instr_q    <= instr_d;
            pc_instr_q <= pc_instr_d;
        end
    end
    // A request in flight is never altered; redirects arriving then are parked in pc_pend
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_pend_d  = pc_pend_q;
        instr_d    = instr_q;
        pc_instr_d = pc_instr_q;
        case (state_q)
            BUSCA: begin
                if (desvio_en) begin
                    if (!alvo_ok) state_d = ERRO;
                    else if (imem_ack) pc_d = desvio_alvo;
                    else begin
                        pc_pend_d = desvio_alvo;
                        state_d   = DESCARTA;
                    end
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_instr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = VALIDO;
                end
            end
            VALIDO: begin
                if (desvio_en) begin
                    if (!alvo_ok) state_d = ERRO;
                    else begin
                        pc_d    = desvio_alvo;
                        state_d = BUSCA;
                    end
                end else if (instr_ready) state_d = BUSCA;
            end
            DESCARTA: begin
                if (desvio_en) begin
                    if (!alvo_ok) state_d = ERRO;
                    else if (imem_ack) begin
                        pc_d    = desvio_alvo;
                        state_d = BUSCA;
                    end else pc_pend_d = desvio_alvo;
                end else if (imem_ack) begin
                    pc_d    = pc_pend_q;
                    state_d = BUSCA;
                end
            end
            ERRO: state_d = ERRO;
        endcase
    end
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed and random checks of the fetch stage against a transaction-level model
module tb_busca_instrucao;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc_instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        desvio_en = 1'b0;
    logic [31:0] desvio_alvo = 32'h0;
    logic        erro_alinhamento;

    busca_instrucao #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .pc_instr(pc_instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .desvio_en(desvio_en),
        .desvio_alvo(desvio_alvo), .erro_alinhamento(erro_alinhamento)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          ndel = 0;
    int          wcnt = 0;
    int          fixed_lat = 1;
    bit          spur = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    bit          m_err = 1'b0;
    bit          prev_valid = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_instr = 32'h0, prev_pci = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        chk("erro_alinhamento", 32'(erro_alinhamento), 32'(m_err));
        if (m_err) begin
            chk("req_in_erro", 32'(imem_req), 32'd0);
            chk("valid_in_erro", 32'(instr_valid), 32'd0);
        end
        if (imem_req && prev_req && !prev_ack) chk("addr_stable", imem_addr, prev_addr);
        chk("req_and_valid", 32'(imem_req && instr_valid), 32'd0);
        if (instr_valid && !prev_valid) begin
            chk("pc_instr", pc_instr, exp_pc);
            chk("instr", instr, mem_word(exp_pc));
            exp_pc += 32'd4;
            ndel++;
        end else if (instr_valid) begin
            chk("instr_hold", instr, prev_instr);
            chk("pc_instr_hold", pc_instr, prev_pci);
        end
        prev_valid = instr_valid;
        prev_instr = instr;
        prev_pci   = pc_instr;
    endtask

    task automatic tick(input bit en, input logic [31:0] alvo, input bit rdy);
        desvio_en   = en;
        desvio_alvo = alvo;
        instr_ready = rdy;
        if (imem_req && (!prev_req || prev_ack)) wcnt = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
        if (imem_req) begin
            imem_ack   = wcnt == 0;
            imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
            if (wcnt > 0) wcnt--;
        end else begin
            imem_ack   = spur && $urandom_range(0, 1) == 1;
            imem_rdata = $urandom();
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
        @(posedge clk);
        if (!m_err && en) begin
            if (alvo[1:0] != 2'b00) m_err = 1'b1;
            else exp_pc = alvo;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        desvio_en   = 1'b0;
        instr_ready = 1'b0;
        imem_ack    = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_erro", 32'(erro_alinhamento), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_instr", pc_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_err = 1'b0;
        exp_pc = RESET_PC;
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_valid = 1'b0;
        wcnt = 0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        monitor();
    endtask

    task automatic run_until(input logic [31:0] target);
        int n = 0;
        while (!(instr_valid && pc_instr == target) && n < 60) begin
            tick(1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("reach_pc", 32'(instr_valid && pc_instr == target), 32'd1);
    endtask

    initial begin
        #2;
        do_reset();
        run_until(32'h0);
        run_until(32'h4);
        run_until(32'h8);
        run_until(32'h10);
        repeat (5) begin
            tick(1'b0, 32'h0, 1'b0);
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_pc", pc_instr, 32'h10);
            chk("bp_instr", instr, mem_word(32'h10));
            chk("bp_req", 32'(imem_req), 32'd0);
        end
        tick(1'b0, 32'h0, 1'b1);
        chk("bp_next_req", 32'(imem_req), 32'd1);
        chk("bp_next_addr", imem_addr, 32'h14);
        run_until(32'h20);
        tick(1'b1, 32'h100, 1'b1);
        chk("rd_valid_drop", 32'(instr_valid), 32'd0);
        chk("rd_req", 32'(imem_req), 32'd1);
        chk("rd_addr", imem_addr, 32'h100);
        run_until(32'h100);
        fixed_lat = 3;
        tick(1'b1, 32'h40, 1'b0);
        chk("pend_addr0", imem_addr, 32'h40);
        tick(1'b1, 32'h200, 1'b0);
        chk("pend_req", 32'(imem_req), 32'd1);
        chk("pend_addr1", imem_addr, 32'h40);
        repeat (2) begin
            tick(1'b0, 32'h0, 1'b1);
            chk("pend_addr_hold", imem_addr, 32'h40);
            chk("pend_no_valid", 32'(instr_valid), 32'd0);
        end
        tick(1'b0, 32'h0, 1'b1);
        chk("pend_valid_after_ack", 32'(instr_valid), 32'd0);
        chk("pend_new_addr", imem_addr, 32'h200);
        fixed_lat = 1;
        run_until(32'h200);
        tick(1'b1, 32'h102, 1'b1);
        chk("mis_erro", 32'(erro_alinhamento), 32'd1);
        spur = 1'b1;
        repeat (4) begin
            tick(1'b1, 32'h300, 1'b1);
            chk("mis_hold_erro", 32'(erro_alinhamento), 32'd1);
            chk("mis_hold_req", 32'(imem_req), 32'd0);
        end
        spur = 1'b0;
        do_reset();
        run_until(RESET_PC);
        tick(1'b1, 32'hFFFF_FFFC, 1'b1);
        run_until(32'hFFFF_FFFC);
        chk("wrap_instr", instr, mem_word(32'hFFFF_FFFC));
        tick(1'b0, 32'h0, 1'b1);
        chk("wrap_req", 32'(imem_req), 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);
        fixed_lat = -1;
        spur = 1'b1;
        ndel = 0;
        for (int i = 0; i < 4000; i++) begin
            if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 399) == 0) do_reset();
            else begin
                logic [31:0] a;
                a = $urandom();
                a[1:0] = $urandom_range(0, 39) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
                tick($urandom_range(0, 7) == 0, a, $urandom_range(0, 2) != 0);
            end
        end
        chk("random_progress", 32'(ndel > 100), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch stage that sits directly upstream of the immediate extender and decoder. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Captures each returned word into an instruction register and presents it with its PC through a valid/ready handshake. Accepts branch/jump redirects from the execute stage, which supplies the target computed from the extended immediate.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned (bits [1:0] = 0).

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  fetch byte address; word-aligned
imem_ack  input  1  memory has returned imem_rdata this cycle
imem_rdata  input  32  instruction word from memory
instr  output  32  instruction register, to extender/decoder
pc_instr  output  32  PC of the word in instr
instr_valid  output  1  instr/pc_instr hold a live instruction
instr_ready  input  1  downstream consumes instr this cycle
desvio_en  input  1  redirect pulse (taken branch/jump)
desvio_alvo  input  32  redirect target address
erro_alinhamento  output  1  sticky misaligned-target flag

Behaviour:
- Reset is asynchronous, active-low (rst_n), on one clock (clk). While rst_n=0: pc=RESET_PC, pc_pend=0, instr=0, pc_instr=0, state=BUSCA, erro_alinhamento=0. After release, imem_req=1 in the first cycle.
- State registers: pc (next fetch address), pc_pend (deferred target), state in {BUSCA, VALIDO, DESCARTA, ERRO}.
- Outputs are decoded from the state:
  - imem_req=1 in BUSCA and DESCARTA only.
  - imem_addr=pc in BUSCA and DESCARTA, otherwise 0.
  - instr_valid=1 in VALIDO only.
  - erro_alinhamento=1 in ERRO only.
- Memory protocol: imem_req and imem_addr stay stable from assertion until the ack cycle. The ack arrives in the same cycle as the request or any later cycle. imem_ack outside BUSCA/DESCARTA is ignored.
- BUSCA, no desvio_en:
  - imem_ack=1: instr<=imem_rdata, pc_instr<=pc, pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go to VALIDO.
  - Otherwise stay in BUSCA.
- VALIDO, no desvio_en: instr_ready=1 goes to BUSCA. No prefetch. With ack in cycle N and ready in N+1, the next request is issued in N+2. instr and pc_instr hold their values until the next capture.
- desvio_en=1 with desvio_alvo[1:0]!=0, in any state except ERRO: go to ERRO. ERRO holds until reset and ignores all inputs.
- desvio_en=1 with an aligned target, by state:
  - VALIDO: pc<=desvio_alvo, go to BUSCA. The held instruction is dropped; instr_valid=0 next cycle. The redirect wins over a simultaneous instr_ready.
  - BUSCA with imem_ack=1 in the same cycle: the returned data is discarded, instr is unchanged, pc<=desvio_alvo, stay in BUSCA.
  - BUSCA with imem_ack=0: the request is outstanding and must not be altered. pc_pend<=desvio_alvo, go to DESCARTA.
  - DESCARTA: pc_pend<=desvio_alvo (last redirect wins).
- DESCARTA: keep the request at the old pc. On imem_ack, discard the data, pc<=pc_pend, go to BUSCA. A desvio_en in the ack cycle loads pc with the new target directly.
- An instruction is never delivered from a fetch that was outstanding when a redirect arrived.
- Mid-operation reset aborts any outstanding request immediately: imem_req=0 combinationally via state=BUSCA? No — while rst_n=0 the state is BUSCA, but imem_req is forced to 0 during reset.

Test Plan:
- Reset with RESET_PC=0 and a memory that acks one cycle after req -> addresses 0,4,8 fetched in order. instr_valid pulses with pc_instr=0,4,8 and instr equal to the memory contents.
- Backpressure: hold instr_ready=0 for 5 cycles with instr valid at pc 0x10 -> instr and pc_instr stable, imem_req=0 throughout. Releasing ready -> req at 0x14 two cycles after the ack cycle.
- Redirect in VALIDO at pc_instr 0x20 with desvio_alvo=0x100 and instr_ready=1 in the same cycle -> instr_valid=0 next cycle, next imem_addr=0x100.
- Redirect while request 0x40 is outstanding (ack 3 cycles later), alvo=0x200 -> imem_addr stays 0x40 until ack, that data is never presented, next request is at 0x200.
- Redirect to 0x102 -> erro_alinhamento=1 next cycle, imem_req=0 and instr_valid=0 thereafter. Further desvio_en is ignored. Asserting rst_n=0 clears the error and restarts at RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC -> fetch delivers pc_instr=0xFFFF_FFFC, next imem_addr=0x0000_0000.
